// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the TDM mux/demux pair
package tdm_pkg;
  localparam int NCH = 4;
  localparam int SLOT_W = 2;
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam logic [SLOT_W-1:0] SLOT_Y0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_Y1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_Y2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_Y3 = 2'd3;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrapping slot index counter with enable, load-to-1 and clear
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);
  always_ff @(posedge clk)
    if (!rst_n || clr) slot <= '0;
    else if (load1) slot <= SLOT_W'(1);
    else if (en) slot <= slot + SLOT_W'(1);
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: frame-synced 4-channel TDM demultiplexer with lock/hunt recovery
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             FS,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             S0,
  output logic             S1,
  output logic             FV,
  output logic             LOCK,
  output logic             ERR
);
  state_t state;
  logic [SLOT_W-1:0] slot;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic locked, data_slot;
  assign locked = state == LOCKED;
  assign data_slot = EN && !FS && locked;
  assign LOCK = locked;
  assign S0 = slot[1];
  assign S1 = slot[0];
  tdm_slot_counter u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (data_slot && slot != SLOT_Y0),
    .load1(EN && FS),
    .clr  (data_slot && slot == SLOT_Y0),
    .slot (slot)
  );
  // any FS restarts the frame; a sync away from slot 0 is flagged but keeps lock
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= HUNT;
      {sh0, sh1, sh2} <= '0;
      {Y0, Y1, Y2, Y3} <= '0;
      FV <= 1'b0;
      ERR <= 1'b0;
    end else begin
      FV <= 1'b0;
      ERR <= 1'b0;
      if (EN && FS) begin
        sh0 <= D;
        state <= LOCKED;
        ERR <= locked && slot != SLOT_Y0;
      end else if (data_slot) begin
        if (slot == SLOT_Y0) begin
          ERR <= 1'b1;
          state <= HUNT;
        end else if (slot == SLOT_Y1) sh1 <= D;
        else if (slot == SLOT_Y2) sh2 <= D;
        else if (slot == SLOT_Y3) begin
          {Y0, Y1, Y2, Y3} <= {sh0, sh1, sh2, D};
          FV <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4
module tb_tdm_demux4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, fs = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] y0, y1, y2, y3;
  logic s0, s1, fv, lock, err;
  int checks = 0, errors = 0;
  logic [15:0] ymodel;
  tdm_demux4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .EN(en), .D(d), .FS(fs),
    .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
    .S0(s0), .S1(s1), .FV(fv), .LOCK(lock), .ERR(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [15:0] y, input logic [1:0] s,
                            input logic f, input logic l, input logic e);
    check({tag, ".y"}, {y3, y2, y1, y0}, y);
    check({tag, ".s"}, {14'd0, s0, s1}, {14'd0, s});
    check({tag, ".fv"}, {15'd0, fv}, {15'd0, f});
    check({tag, ".lock"}, {15'd0, lock}, {15'd0, l});
    check({tag, ".err"}, {15'd0, err}, {15'd0, e});
  endtask
  task automatic step(input logic e, input logic f, input logic [3:0] v);
    @(negedge clk);
    en = e;
    fs = f;
    d = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(1, 1, 4'hf);
    step(1, 1, 4'hf);
    expect_out("reset", 16'h0000, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 1, 4'h1); expect_out("lock0", 16'h0000, 2'b01, 0, 1, 0);
    step(1, 0, 4'h2); expect_out("lock1", 16'h0000, 2'b10, 0, 1, 0);
    step(1, 0, 4'h3); expect_out("lock2", 16'h0000, 2'b11, 0, 1, 0);
    step(1, 0, 4'h4); expect_out("lock3", 16'h4321, 2'b00, 1, 1, 0);
    step(0, 1, 4'hf); expect_out("hold", 16'h4321, 2'b00, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, 4'(5 + i));
      expect_out("gap_en", i == 3 ? 16'h8765 : 16'h4321, 2'(i + 1), i == 3, 1, 0);
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 4'he);
        expect_out("gap_idle", i == 3 ? 16'h8765 : 16'h4321, 2'(i + 1), 0, 1, 0);
      end
    end
    step(1, 1, 4'ha); step(1, 0, 4'hb); step(1, 0, 4'hc); step(1, 0, 4'hd);
    expect_out("pre_early", 16'hdcba, 2'b00, 1, 1, 0);
    step(1, 1, 4'he); step(1, 0, 4'hf);
    expect_out("early_f", 16'hdcba, 2'b10, 0, 1, 0);
    step(1, 1, 4'h9); expect_out("early_g", 16'hdcba, 2'b01, 0, 1, 1);
    step(1, 0, 4'h8); expect_out("early_h", 16'hdcba, 2'b10, 0, 1, 0);
    step(1, 0, 4'h7); expect_out("early_i", 16'hdcba, 2'b11, 0, 1, 0);
    step(1, 0, 4'h6); expect_out("early_j", 16'h6789, 2'b00, 1, 1, 0);
    step(1, 0, 4'h5); expect_out("miss", 16'h6789, 2'b00, 0, 0, 1);
    step(1, 0, 4'h1); expect_out("hunt", 16'h6789, 2'b00, 0, 0, 0);
    step(1, 1, 4'h1); step(1, 0, 4'h2); step(1, 0, 4'h3);
    expect_out("relock", 16'h6789, 2'b11, 0, 1, 0);
    step(1, 0, 4'h4); expect_out("relock3", 16'h4321, 2'b00, 1, 1, 0);
    step(1, 1, 4'h9); step(1, 0, 4'ha);
    rst_n = 1'b0;
    step(1, 0, 4'hb); expect_out("rst_mid", 16'h0000, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 4'hc); expect_out("rst_hunt", 16'h0000, 2'b00, 0, 0, 0);
    step(1, 1, 4'h3); step(1, 0, 4'h4); step(1, 0, 4'h5); step(1, 0, 4'h6);
    expect_out("post_rst", 16'h6543, 2'b00, 1, 1, 0);
    ymodel = 16'h6543;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) begin
        step(1, i == 0, 4'(f * 4 + i + 1));
        if (i == 3) ymodel = {4'(f * 4 + 4), 4'(f * 4 + 3), 4'(f * 4 + 2), 4'(f * 4 + 1)};
        expect_out("b2b", ymodel, 2'(i + 1), i == 3, 1, 0);
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
